shiftadd_accumulator: RTL

Sequential accumulation stage directly downstream of the 4x4 shift-add multiplier. It takes the multiplier's 8-bit products through a valid/ready handshake and sums them into a wider accumulator. It closes a group on an explicit last flag or when a term-count limit is reached. It then presents the group sum and term count to the next stage, so that the multiplier plus this block form a dot-product (MAC) datapath.

---
 rtl/shiftadd_pkg.sv | 12 +
 rtl/shiftadd_accumulator_if.sv | 28 ++
 rtl/shiftadd_acc_add.sv | 26 ++
 rtl/shiftadd_accumulator.sv | 109 ++++++++++
 4 files changed

// File: rtl/shiftadd_pkg.sv
// Shared types and default widths for the shift-add accumulator slice.
package shiftadd_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    localparam int PROD_W_DEF = 8;
    localparam int ACC_W_DEF  = 12;

endpackage

// File: rtl/shiftadd_accumulator_if.sv
// Product-in / group-result-out bundle between multiplier, accumulator and the next stage.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both 1;
// the sender holds data stable while valid=1 and ready=0, and ready never depends on valid.
interface shiftadd_accumulator_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12,
    parameter int CNT_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_product;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, in_product, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_product, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/shiftadd_acc_add.sv
// Accumulator adder: zero-extends the product, reports carry out of the top bit.
// Optional clamp to all-ones on carry when SHIFTADD_ACC_SAT_EN is defined.
module shiftadd_acc_add
    import shiftadd_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] prod_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              carry_o
);
    logic [ACC_W:0] raw;

    always_comb begin
        raw     = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
        carry_o = raw[ACC_W];
`ifdef SHIFTADD_ACC_SAT_EN
        // Once clamped, later non-zero adds carry again, so the clamp holds for the group.
        sum_o   = raw[ACC_W] ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
        sum_o   = raw[ACC_W-1:0];
`endif
    end
endmodule

// File: rtl/shiftadd_accumulator.sv
// Group accumulator behind the 4x4 shift-add multiplier; closes on in_last or MAX_TERMS.
// Saturating accumulation is selected with SHIFTADD_ACC_SAT_EN (see shiftadd_acc_add).
module shiftadd_accumulator
    import shiftadd_pkg::*;
#(
    parameter int PROD_W    = PROD_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int MAX_TERMS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    shiftadd_accumulator_if.slave  bus,
    output acc_state_t             state_o
);
    localparam int CNT_W = $clog2(MAX_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_TERMS - 1);

    acc_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_carry;
    logic             accept;

    shiftadd_acc_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc_i   (acc_q),
        .prod_i  (bus.in_product),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    // in_ready_q is low for one cycle after reset, so gate acceptance on it as well.
    assign accept = bus.in_valid && in_ready_q && (state_q == ACCUM);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d = add_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    ovf_d = ovf_q | add_carry;
                    if (bus.in_last || (cnt_q == LAST_IDX)) begin
                        state_d     = HOLD;
                        out_sum_d   = add_sum;
                        out_count_d = cnt_q + CNT_W'(1);
                        out_ovf_d   = ovf_q | add_carry;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= (state_d == ACCUM);
            out_valid_q <= (state_d == HOLD);
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;
    assign state_o       = state_q;
endmodule
